// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin mux/arbiter slice.
package mux_pkg;

  localparam int MODE_RR     = 0;
  localparam int MODE_FIXED  = 1;
  localparam int MODE_SELECT = 2;

  // Ceiling log2, used to size channel-index fields at elaboration time.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant generator for the mux: round-robin, fixed-priority or explicit select.
// Owns the round-robin pointer, which only moves on an accepted transfer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_RR,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] request,
  input  logic [SEL_W-1:0]    select_line,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_index
);

  logic [SEL_W-1:0] ptr;

  // One-hot grant selection according to the configured mode.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    idx         = 0;
    case (MODE)
      MODE_SELECT: begin
        if (32'(select_line) < CHANNELS && request[select_line]) begin
          grant[select_line] = 1'b1;
          grant_index        = select_line;
        end
      end
      MODE_FIXED: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (!found && request[i]) begin
            grant[i]    = 1'b1;
            grant_index = SEL_W'(i);
            found       = 1'b1;
          end
        end
      end
      default: begin
        // Scan upward from the pointer, wrapping past the top channel.
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          idx = 32'(ptr) + k;
          if (idx >= CHANNELS) idx = idx - CHANNELS;
          if (!found && request[idx]) begin
            grant[idx]  = 1'b1;
            grant_index = SEL_W'(idx);
            found       = 1'b1;
          end
        end
      end
    endcase
  end

  // Pointer advances past the granted channel on a transfer; round-robin only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (MODE == MODE_RR && advance) begin
      ptr <= (grant_index == SEL_W'(CHANNELS - 1)) ? '0 : grant_index + 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel valid/ready selector with arbitration and a registered output stage.
module rr_mux_arbiter
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_RR,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] inData,
  input  logic [CHANNELS-1:0]       inValid,
  output logic [CHANNELS-1:0]       inReady,
  input  logic [SEL_W-1:0]          selectLine,
  output logic [WIDTH-1:0]          outData,
  output logic [SEL_W-1:0]          outChannel,
  output logic                      outValid,
  input  logic                      outReady
);

  logic                load_en;
  logic                transfer;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_index;
  logic [WIDTH-1:0]    sel_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE)
  ) u_arbiter (
    .clk         (clk),
    .reset       (reset),
    .request     (inValid),
    .select_line (selectLine),
    .advance     (transfer),
    .grant       (grant),
    .grant_index (grant_index)
  );

  // Register can take a word when empty or being drained this cycle.
  assign load_en  = !outValid || outReady;
  assign inReady  = (load_en && !reset) ? grant : '0;
  assign transfer = |(inReady & inValid);
  assign sel_data = inData[32'(grant_index)*WIDTH +: WIDTH];

  // Output stage: load on transfer, clear valid on drain, hold on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid   <= 1'b0;
      outData    <= '0;
      outChannel <= '0;
    end else if (transfer) begin
      outValid   <= 1'b1;
      outData    <= sel_data;
      outChannel <= grant_index;
    end else if (outValid && outReady) begin
      outValid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench: one instance per selection mode, checks via immediate assertions.
module tb_rr_mux_arbiter;

  logic clk;
  logic reset;

  // Round-robin instance
  logic [31:0] d0;
  logic [3:0]  v0, rdy0;
  logic [1:0]  sel0, oc0;
  logic [7:0]  od0;
  logic        ov0, ordy0;

  // Fixed-priority instance
  logic [31:0] d1;
  logic [3:0]  v1, rdy1;
  logic [1:0]  sel1, oc1;
  logic [7:0]  od1;
  logic        ov1, ordy1;

  // Explicit-select instance
  logic [31:0] d2;
  logic [3:0]  v2, rdy2;
  logic [1:0]  sel2, oc2;
  logic [7:0]  od2;
  logic        ov2, ordy2;

  int compared;
  int mismatched;

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_rr (
    .clk(clk), .reset(reset), .inData(d0), .inValid(v0), .inReady(rdy0),
    .selectLine(sel0), .outData(od0), .outChannel(oc0), .outValid(ov0), .outReady(ordy0));

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_fix (
    .clk(clk), .reset(reset), .inData(d1), .inValid(v1), .inReady(rdy1),
    .selectLine(sel1), .outData(od1), .outChannel(oc1), .outValid(ov1), .outReady(ordy1));

  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .MODE(2)) u_sel (
    .clk(clk), .reset(reset), .inData(d2), .inValid(v2), .inReady(rdy2),
    .selectLine(sel2), .outData(od2), .outChannel(oc2), .outValid(ov2), .outReady(ordy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rr_data [4];
    rr_data[0] = 8'h11; rr_data[1] = 8'h22; rr_data[2] = 8'h33; rr_data[3] = 8'h44;
    compared   = 0;
    mismatched = 0;

    reset = 1'b1;
    d0 = 32'h44332211; v0 = 4'hF; sel0 = '0; ordy0 = 1'b1;
    d1 = 32'h44332211; v1 = 4'h0; sel1 = '0; ordy1 = 1'b1;
    d2 = 32'h00040800; v2 = 4'h0; sel2 = '0; ordy2 = 1'b1;

    // Reset state with all requests high
    #2;
    chk("rst_inReady", 32'(rdy0), 32'h0);
    chk("rst_outValid", 32'(ov0), 32'h0);
    chk("rst_outData", 32'(od0), 32'h0);
    chk("rst_outChannel", 32'(oc0), 32'h0);
    #10;
    reset = 1'b0;
    #1;
    chk("first_grant", 32'(rdy0), 32'h1);

    // Round-robin sweep, one word per cycle
    for (int k = 0; k < 8; k++) begin
      if (k > 0) chk($sformatf("rr_ready_%0d", k), 32'(rdy0), 32'(1 << (k % 4)));
      tick();
      chk($sformatf("rr_valid_%0d", k), 32'(ov0), 32'h1);
      chk($sformatf("rr_chan_%0d", k), 32'(oc0), 32'(k % 4));
      chk($sformatf("rr_data_%0d", k), 32'(od0), 32'(rr_data[k % 4]));
    end

    // Two more transfers leave 0x22 (channel 1) in the register, pointer at 2
    tick();
    tick();
    chk("bp_setup_data", 32'(od0), 32'h22);
    ordy0 = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_ready_%0d", k), 32'(rdy0), 32'h0);
      tick();
      chk($sformatf("bp_valid_%0d", k), 32'(ov0), 32'h1);
      chk($sformatf("bp_data_%0d", k), 32'(od0), 32'h22);
      chk($sformatf("bp_chan_%0d", k), 32'(oc0), 32'h1);
    end
    ordy0 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(rdy0), 32'h4);
    tick();
    chk("bp_release_valid", 32'(ov0), 32'h1);
    chk("bp_release_data", 32'(od0), 32'h33);
    chk("bp_release_chan", 32'(oc0), 32'h2);

    // Wrap: pointer at 3, only channel 0 requesting
    v0 = 4'b0001;
    #1;
    chk("wrap_ready", 32'(rdy0), 32'h1);
    tick();
    chk("wrap_chan", 32'(oc0), 32'h0);
    chk("wrap_data", 32'(od0), 32'h11);
    v0 = 4'hF;
    #1;
    chk("wrap_ptr_next", 32'(rdy0), 32'h2);
    tick();
    chk("pre_rst_valid", 32'(ov0), 32'h1);
    chk("pre_rst_chan", 32'(oc0), 32'h1);

    // Mid-operation reset pulse between edges
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(ov0), 32'h0);
    chk("midrst_data", 32'(od0), 32'h0);
    chk("midrst_ready", 32'(rdy0), 32'h0);
    reset = 1'b0;
    #1;
    chk("postrst_ready", 32'(rdy0), 32'h1);
    tick();
    chk("postrst_chan", 32'(oc0), 32'h0);
    chk("postrst_data", 32'(od0), 32'h11);
    v0 = 4'h0;
    tick();
    chk("drain_valid", 32'(ov0), 32'h0);
    chk("drain_hold_data", 32'(od0), 32'h11);

    // Fixed priority: channel 1 starves channel 3
    v1 = 4'b1010;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fix_ready_%0d", k), 32'(rdy1), 32'h2);
      tick();
      chk($sformatf("fix_chan_%0d", k), 32'(oc1), 32'h1);
      chk($sformatf("fix_data_%0d", k), 32'(od1), 32'h22);
    end
    v1 = 4'b1000;
    #1;
    chk("fix_ready_3", 32'(rdy1), 32'h8);
    tick();
    chk("fix_chan_3", 32'(oc1), 32'h3);
    chk("fix_data_3", 32'(od1), 32'h44);

    // Explicit select
    v2 = 4'b0110;
    sel2 = 2'd1;
    #1;
    chk("sel1_ready", 32'(rdy2), 32'h2);
    tick();
    chk("sel1_data", 32'(od2), 32'h08);
    chk("sel1_chan", 32'(oc2), 32'h1);
    sel2 = 2'd2;
    #1;
    chk("sel2_ready", 32'(rdy2), 32'h4);
    tick();
    chk("sel2_data", 32'(od2), 32'h04);
    chk("sel2_chan", 32'(oc2), 32'h2);
    v2 = 4'b0010;
    #1;
    chk("sel_none_ready", 32'(rdy2), 32'h0);
    tick();
    chk("sel_none_valid", 32'(ov2), 32'h0);
    chk("sel_none_data", 32'(od2), 32'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised N-channel, WIDTH-bit selector with valid/ready handshakes and a registered output stage, used in the processor datapath wherever several producers compete for one consumer (e.g. write-back, memory-port sharing).
- Three selection modes are supported: round-robin, fixed priority, and explicit select.
- It generalises the combinational 2:1 byte mux with arbitration, backpressure and one cycle of buffering.

Parameters:
- WIDTH, 8, data width per channel in bits.
- CHANNELS, 4, number of input channels; legal range 2 to 16.
- MODE, 0, selection mode: 0 = round-robin, 1 = fixed priority (lowest index wins), 2 = explicit select via selectLine.
- SEL_W, derived localparam = clog2(CHANNELS), channel index width; not overridable.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- inData  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- inValid  input  CHANNELS  per-channel request/valid.
- inReady  output  CHANNELS  per-channel accept, combinational; at most one bit is high.
- selectLine  input  SEL_W  channel to pass in MODE 2; ignored in other modes.
- outData  output  WIDTH  registered selected data.
- outChannel  output  SEL_W  registered index of the channel that produced outData.
- outValid  output  1  output register holds valid data.
- outReady  input  1  consumer accept.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - outValid=0, outData=0, outChannel=0, rr pointer=0.
  - inReady is forced to all zeros.
- loadEn = !outValid || outReady. The output register accepts new data whenever it is empty or is being drained in the same cycle.
- grant (one-hot, combinational):
  - MODE 0: the lowest i at or above the pointer, wrapping around, with inValid[i]=1.
  - MODE 1: the lowest i with inValid[i]=1.
  - MODE 2: grant[selectLine] if inValid[selectLine]=1. If selectLine >= CHANNELS, there is no grant.
- inReady[i] = loadEn && grant[i] && !reset. A transfer on channel i happens when inValid[i] && inReady[i].
- On a transfer:
  - outData <= channel i data; outChannel <= i; outValid <= 1.
  - MODE 0 only: pointer <= (i+1) mod CHANNELS.
- No transfer while outValid && outReady: outValid <= 0. outData and outChannel hold their last values.
- No transfer while outValid && !outReady: all outputs hold (stall). Producers must hold inData and inValid until they are accepted.
- Latency and throughput:
  - Input-accept to outValid is 1 cycle.
  - Sustained throughput is 1 word per cycle with outReady held high.
  - Simultaneous drain and load in one cycle is legal and gives no bubble.
- The pointer moves only on a transfer. It never moves on stalls or idle cycles, and it is unused and held at 0 in MODE 1 and MODE 2.
- Fairness (MODE 0): with all channels continuously valid, grants cycle 0,1,...,CHANNELS-1,0,... Each channel waits at most CHANNELS-1 transfers.
- Wrap-around: when the pointer is at CHANNELS-1 and only channel 0 is valid, channel 0 is granted and the pointer becomes 1.
- Reset asserted mid-transfer: in-flight data is discarded, outValid drops immediately (asynchronously), and arbitration restarts from channel 0 after deassertion.
- outData and outChannel are don't-care when outValid=0, but they must match the values given above for the checker.

Decomposition:
- Package mux_pkg:
  - mode constants MODE_RR=0, MODE_FIXED=1, MODE_SELECT=2.
  - clog2 helper function.
- Sub-module rr_arbiter (parameters CHANNELS, MODE):
  - inputs: request vector, selectLine, advance strobe.
  - outputs: one-hot grant and grant index.
  - owns the pointer register, with the same clk/reset.
- The top level holds the output register, the loadEn/handshake logic and the data slicing.

Test Plan:
- Reset check: assert reset with all inValid=1 -> inReady=0000, outValid=0, outData=0x00. Release reset, CHANNELS=4, MODE 0, outReady=1 -> the first transfer is channel 0.
- Round-robin sweep: MODE 0, inData = {0x44,0x33,0x22,0x11}, all valid, outReady=1 for 8 cycles -> outChannel sequence 0,1,2,3,0,1,2,3 and outData 0x11,0x22,0x33,0x44 repeating, one word per cycle from cycle 1.
- Backpressure: outValid=1 with outData=0x22 and outReady=0 for 3 cycles -> outData stays 0x22, inReady=0000 and the pointer is unchanged. Raise outReady -> the next channel loads in that same cycle with no bubble.
- Fixed priority: MODE 1, inValid=1010 (channels 1 and 3) -> channel 1 is granted every cycle and channel 3 is starved until inValid[1]=0, then channel 3 is granted.
- Explicit select: MODE 2, inData ch1=0x08, ch2=0x04. selectLine=1 -> outData=0x08 next cycle. selectLine=2 -> 0x04. inValid[2]=0 with selectLine=2 -> no transfer and outValid drops after the drain.
- Wrap and mid-operation reset: MODE 0, pointer at 3, only inValid[0]=1 -> channel 0 granted, pointer becomes 1. Pulse reset while outValid=1 -> outValid=0 asynchronously and the next grant starts from channel 0.
